// File: rtl/usb_pkg.sv
// usb_pkg: shared USB receive types, CRC constants and field geometry
package usb_pkg;
  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010
  } pid_t;
  typedef enum logic [2:0] {IDLE, SYNC, PID, TOKEN, DATA, HSHK, EOPCHK} rx_state_t;
  typedef enum logic [1:0] {K_TOKEN, K_DATA, K_ACK, K_NAK} pkt_kind_t;
  // sync byte as shifted in LSB-first: seven zeros then a one
  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [4:0] CRC5_POLY = 5'h05;
  localparam logic [4:0] CRC5_INIT = 5'h1F;
  localparam logic [4:0] CRC5_RESIDUAL = 5'h0C;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam int PID_W = 4;
  localparam int ADDR_W = 7;
  localparam int ENDP_W = 4;
  localparam int DATA_W = 64;
  localparam logic [6:0] ADDR_END = 7'd7;
  localparam logic [6:0] ENDP_END = 7'd11;
  localparam logic [6:0] DATA_END = 7'd64;
  localparam logic [6:0] TOKEN_LAST = 7'd15;
  localparam logic [6:0] DATA_LAST = 7'd79;
  localparam logic [6:0] CNT_MAX = 7'd127;
  function automatic rx_state_t pid_next(input logic [3:0] p);
    case (p)
      PID_OUT, PID_IN, PID_SETUP: return TOKEN;
      PID_DATA0, PID_DATA1: return DATA;
      PID_ACK, PID_NAK: return HSHK;
      default: return EOPCHK;
    endcase
  endfunction
  function automatic pkt_kind_t pid_kind(input logic [3:0] p);
    return p == PID_ACK ? K_ACK : p == PID_NAK ? K_NAK : pid_next(p) == DATA ? K_DATA : K_TOKEN;
  endfunction
endpackage

// File: rtl/usb_rx_decoder_if.sv
// usb_rx_decoder_if: serial bit input and decoded packet result bundle
interface usb_rx_decoder_if;
  import usb_pkg::*;
  logic inb;
  logic bit_valid;
  logic recving;
  logic [PID_W-1:0] pid;
  logic [ENDP_W-1:0] endp;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic pktready;
  logic ack;
  logic nak;
  logic error;
  modport master (
    output inb, bit_valid, recving,
    input pid, endp, addr, data, pktready, ack, nak, error
  );
  modport slave (
    input inb, bit_valid, recving,
    output pid, endp, addr, data, pktready, ack, nak, error
  );
endinterface

// File: rtl/usb_rx_decoder_crc_checker.sv
// rx_crc_checker: serial CRC5/CRC16 registers with residual check
module rx_crc_checker
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst_L,
  input  logic clr,
  input  logic en,
  input  logic sel,
  input  logic inb,
  output logic residual_ok
);
  logic [4:0] c5;
  logic [15:0] c16;
  logic fb5, fb16;
  assign fb5 = c5[4] ^ inb;
  assign fb16 = c16[15] ^ inb;
  assign residual_ok = sel ? c16 == CRC16_RESIDUAL : c5 == CRC5_RESIDUAL;
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      c5 <= CRC5_INIT;
      c16 <= CRC16_INIT;
    end else if (clr) begin
      c5 <= CRC5_INIT;
      c16 <= CRC16_INIT;
    end else if (en) begin
      if (!sel) c5 <= {c5[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : 5'h00);
      if (sel) c16 <= {c16[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'h0000);
    end
  end
endmodule

// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: finds SYNC, checks PID, captures fields, CRC-checks and strobes a result after EOP
module usb_rx_decoder
  import usb_pkg::*;
(
  input logic clk,
  input logic rst_L,
  usb_rx_decoder_if.slave rx
);
  rx_state_t state_q, state_d, pid_state;
  pkt_kind_t kind_q, kind_d;
  logic [6:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic wait_eop, consume, eop, pid_ok;
  logic [6:0] pid_sh;
  logic [7:0] pid_byte;
  logic [3:0] pid_cap, pid_q;
  logic [ADDR_W-1:0] addr_sh, addr_q;
  logic [ENDP_W-1:0] endp_sh, endp_q;
  logic [DATA_W-1:0] data_sh, data_q;
  logic crc_ok, bad_d, pkt_d, ack_d, nak_d;
  logic pkt_q, ack_q, nak_q, bad_q;
  // a packet already on the bus when reset releases is skipped until recving drops
  assign consume = rx.recving & rx.bit_valid & ~wait_eop;
  assign eop = ~rx.recving & (state_q != IDLE);
  assign pid_byte = {rx.inb, pid_sh};
  assign pid_ok = pid_byte[7:4] == ~pid_byte[3:0];
  assign pid_state = pid_next(pid_byte[3:0]);
  rx_crc_checker u_crc (
    .clk(clk),
    .rst_L(rst_L),
    .clr(state_q == IDLE || eop),
    .en(consume && (state_q == TOKEN || state_q == DATA)),
    .sel(kind_q == K_DATA),
    .inb(rx.inb),
    .residual_ok(crc_ok)
  );
  always_comb begin
    state_d = state_q;
    err_d = err_q;
    kind_d = kind_q;
    cnt_d = consume ? (cnt_q == CNT_MAX ? cnt_q : cnt_q + 7'd1) : cnt_q;
    bad_d = 1'b0;
    pkt_d = 1'b0;
    ack_d = 1'b0;
    nak_d = 1'b0;
    if (eop) begin
      // only HSHK or a completed field in EOPCHK means an exact bit count
      bad_d = err_q || !(state_q == HSHK || state_q == EOPCHK) || (state_q == EOPCHK && !crc_ok);
      pkt_d = !bad_d && (kind_q == K_TOKEN || kind_q == K_DATA);
      ack_d = !bad_d && kind_q == K_ACK;
      nak_d = !bad_d && kind_q == K_NAK;
      state_d = IDLE;
      err_d = 1'b0;
      cnt_d = 7'd0;
    end else if (consume) begin
      case (state_q)
        IDLE: begin
          state_d = rx.inb == SYNC_PATTERN[0] ? SYNC : EOPCHK;
          err_d = rx.inb != SYNC_PATTERN[0];
          cnt_d = 7'd1;
        end
        SYNC: begin
          if (rx.inb != SYNC_PATTERN[cnt_q[2:0]]) begin
            state_d = EOPCHK;
            err_d = 1'b1;
          end else if (cnt_q == 7'd7) begin
            state_d = PID;
            cnt_d = 7'd0;
          end
        end
        PID: begin
          if (cnt_q == 7'd7) begin
            state_d = pid_ok ? pid_state : EOPCHK;
            err_d = !pid_ok || pid_state == EOPCHK;
            kind_d = pid_kind(pid_byte[3:0]);
            cnt_d = 7'd0;
          end
        end
        TOKEN: state_d = cnt_q == TOKEN_LAST ? EOPCHK : TOKEN;
        DATA: state_d = cnt_q == DATA_LAST ? EOPCHK : DATA;
        HSHK, EOPCHK: begin
          state_d = EOPCHK;
          err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= IDLE;
      kind_q <= K_TOKEN;
      cnt_q <= 7'd0;
      err_q <= 1'b0;
      wait_eop <= 1'b1;
      pid_sh <= '0;
      pid_cap <= '0;
      addr_sh <= '0;
      endp_sh <= '0;
      data_sh <= '0;
      pid_q <= '0;
      addr_q <= '0;
      endp_q <= '0;
      data_q <= '0;
      pkt_q <= 1'b0;
      ack_q <= 1'b0;
      nak_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q <= kind_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      wait_eop <= wait_eop & rx.recving;
      if (consume && state_q == PID) pid_sh <= pid_byte[7:1];
      if (consume && state_q == PID && cnt_q == 7'd7) pid_cap <= pid_byte[3:0];
      if (consume && state_q == TOKEN && cnt_q < ADDR_END) addr_sh <= {rx.inb, addr_sh[ADDR_W-1:1]};
      if (consume && state_q == TOKEN && cnt_q >= ADDR_END && cnt_q < ENDP_END) endp_sh <= {rx.inb, endp_sh[ENDP_W-1:1]};
      if (consume && state_q == DATA && cnt_q < DATA_END) data_sh <= {rx.inb, data_sh[DATA_W-1:1]};
      if (pkt_d || ack_d || nak_d) pid_q <= pid_cap;
      if (pkt_d && kind_q == K_TOKEN) addr_q <= addr_sh;
      if (pkt_d && kind_q == K_TOKEN) endp_q <= endp_sh;
      if (pkt_d && kind_q == K_DATA) data_q <= data_sh;
      pkt_q <= pkt_d;
      ack_q <= ack_d;
      nak_q <= nak_d;
      bad_q <= bad_d;
    end
  end
  assign rx.pid = pid_q;
  assign rx.addr = addr_q;
  assign rx.endp = endp_q;
  assign rx.data = data_q;
  assign rx.pktready = pkt_q;
  assign rx.ack = ack_q;
  assign rx.nak = nak_q;
  assign rx.error = bad_q;
endmodule
